// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
// Operation encoding matches the EX-stage decoder's 2-bit op field.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide datapath.
// Multiply: acc = {partial, multiplier}; Divide: acc = {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : (WIDTH+1)'(0));
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // Remainder is always below the divisor, so the top bit of diff is a clean borrow flag.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes at issue; signs are restored in the FIX cycle.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic neg, input logic [2*WIDTH-1:0] x);
        return neg ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    md_state_t          state, state_next;
    logic [CNT_W-1:0]   count;
    muldiv_op_t         op_in;
    logic               accept;
    logic               in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;

    logic               div_q;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   step_operand;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign op_in    = muldiv_op_t'(op);
    assign accept   = (state == IDLE) && start;
    assign in_neg_a = op_is_signed(op_in) && srca[WIDTH-1];
    assign in_neg_b = op_is_signed(op_in) && srcb[WIDTH-1];
    assign in_mag_a = neg_if(in_neg_a, srca);
    assign in_mag_b = neg_if(in_neg_b, srcb);

    // Multiply steps add the multiplicand; divide steps subtract the divisor.
    assign step_operand = div_q ? mag_b : mag_a;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (div_q),
        .acc      (acc),
        .operand  (step_operand),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = busy && (start || mfhi || mflo || mthi || mtlo);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (state == RUN) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            div_q <= op_is_div(op_in);
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            acc   <= op_is_div(op_in) ? {WIDTH'(0), in_mag_a} : {WIDTH'(0), in_mag_b};
        end else if (state == RUN) begin
            acc <= acc_next;
        end
    end

    // Sign restoration: product and quotient follow the operand-sign XOR, remainder follows the dividend.
    always_comb begin
        prod   = neg_wide_if(neg_a ^ neg_b, acc);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_q) begin
            if (mag_b == '0) begin
                res_hi = neg_if(neg_a, mag_a);
                res_lo = '1;
            end else begin
                res_hi = neg_if(neg_a, acc[2*WIDTH-1:WIDTH]);
                res_lo = neg_if(neg_a ^ neg_b, acc[WIDTH-1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == IDLE && !start) begin
            if (mthi) hi <= srca;
            if (mtlo) lo <= srca;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of arithmetic vectors plus
// hand-written sequences for stalls, moves and mid-operation reset.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        mfhi, mflo, mthi, mtlo;
    logic [31:0] hi, lo;
    logic        busy, stall;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .mfhi    (mfhi),
        .mflo    (mflo),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns the cycle (after the start edge) in which busy first reads low.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        start = 0; op = 0; srca = 0; srcb = 0;
        mfhi = 0; mflo = 0; mthi = 0; mtlo = 0;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9] = '{2'b01, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};

        tick();
        tick();
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        mflo = 1'b1;
        #1;
        check("reset_stall", {31'b0, stall}, 32'h0);
        mflo = 1'b0;
        reset_n = 1'b1;
        tick();

        // Table vectors, issued back-to-back in the first idle cycle.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_latency", i), cyc, 34);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Dependent MFLO held through the operation, with a second start mid-flight.
        start = 1'b1; op = 2'b01; srca = 32'd3; srcb = 32'd4;
        tick();
        start = 1'b0;
        mflo  = 1'b1;
        cyc   = 1;
        while (busy && cyc < 100) begin
            if (cyc == 5) begin
                start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            check($sformatf("mflo_stall_c%0d", cyc), {31'b0, stall}, 32'h1);
            check($sformatf("mflo_lo_hold_c%0d", cyc), lo, 32'h0000002A);
            tick();
            cyc++;
        end
        check("mflo_release_cycle", cyc, 34);
        check("mflo_release_stall", {31'b0, stall}, 32'h0);
        check("mflo_new_lo", lo, 32'd12);
        check("mflo_new_hi", hi, 32'd0);
        mflo = 1'b0;
        tick();
        check("mflo_no_restart", {31'b0, busy}, 32'h0);

        // MTHI in idle: one edge, no stall.
        mthi = 1'b1; srca = 32'h12345678;
        #1;
        check("mthi_idle_stall", {31'b0, stall}, 32'h0);
        tick();
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h12345678);

        // MTLO during busy is ignored until re-presented.
        start = 1'b1; op = 2'b01; srca = 32'd5; srcb = 32'd5;
        tick();
        start = 1'b0;
        tick();
        mtlo = 1'b1; srca = 32'hCAFEF00D;
        #1;
        check("mtlo_busy_stall", {31'b0, stall}, 32'h1);
        tick();
        mtlo = 1'b0;
        check("mtlo_busy_lo", lo, 32'd12);
        cyc = 3;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        check("mtlo_op_cycle", cyc, 34);
        check("mtlo_op_lo", lo, 32'd25);
        check("mtlo_op_hi", hi, 32'd0);
        mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        check("mtlo_represent_lo", lo, 32'hCAFEF00D);

        // Reset pulsed at RUN count 10 aborts with no partial write.
        start = 1'b1; op = 2'b01; srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("pre_reset_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        run_op(2'b01, 32'd6, 32'd7, cyc);
        check("post_reset_latency", cyc, 34);
        check("post_reset_lo", lo, 32'd42);
        check("post_reset_hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide unit with its sequencing FSM, attached to the EX stage of the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU one bit per cycle into the architectural HI/LO registers. It also services MFHI/MFLO/MTHI/MTLO, and raises a stall toward the hazard logic whenever the pipeline touches HI/LO or issues a new operation while an operation is in flight.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; valid with start
- srca  in  WIDTH  rs value (multiplicand / dividend)
- srcb  in  WIDTH  rt value (multiplier / divisor)
- mfhi, mflo  in  1  EX-stage read of HI / LO
- mthi, mtlo  in  1  EX-stage write of HI / LO from srca
- hi, lo  out  WIDTH  architectural HI / LO
- busy  out  1  operation in flight
- stall  out  1  hold IF/ID/EX, bubble MEM

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start: latch op, operand signs, |srca|, |srcb| for signed ops and raw values for unsigned ops; count<=0; go to RUN.
- RUN: one step per cycle. Multiply: shift-add into a 2*WIDTH accumulator. Divide: restoring shift-subtract giving a WIDTH-bit quotient and remainder. count increments each cycle. At count==WIDTH-1, go to FIX.
- FIX: apply sign correction and write hi/lo. Go to IDLE.
- Mult result: hi = upper WIDTH bits, lo = lower WIDTH bits. Signed mult negates the 2*WIDTH product if the operand signs differ.
- Div result: lo = quotient, truncated toward zero; hi = remainder, which takes the dividend's sign.
- Divide by zero, signed or unsigned: hi = srca, lo = all ones. Latency is unchanged.
- Signed -2^(WIDTH-1) / -1 wraps: lo = 0x80000000, hi = 0.
- mthi/mtlo in IDLE: hi/lo <= srca at the next edge.
- start together with mthi/mtlo in IDLE: start wins and the move is ignored. The decoder never issues both.
- busy = (state != IDLE).
- stall = busy & (start | mfhi | mflo | mthi | mtlo). It is combinational.
- While busy, start, mthi and mtlo are ignored. The pipeline re-presents them after the stall releases.
- hi/lo outputs are the registers themselves. Mid-operation values stay at the previous result until FIX.

## Timing
- Reset, asynchronous: state IDLE, count 0, hi = lo = 0, busy = 0, stall = 0. Reset mid-RUN/FIX aborts the operation with no partial write.
- start sampled at edge 0 → busy high for cycles 1 through WIDTH+1.
- The FIX edge (edge WIDTH+1) updates hi/lo. busy is low from cycle WIDTH+2.
- Total issue-to-result latency is WIDTH+1 edges, 33 for WIDTH=32.
- A dependent MFLO stalls through cycle WIDTH+1 and reads the new lo in cycle WIDTH+2.
- Back-to-back: a start presented in the first idle cycle is accepted at that edge, with no dead cycle.
- mthi/mtlo latency: 1 edge.

## Structure
- muldiv_pkg holds:
  - typedef enum muldiv_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}
  - typedef enum md_state_t {IDLE, RUN, FIX}
  - localparam default WIDTH
- Sub-module muldiv_step: combinational single iteration. Inputs are op class, accumulator and operand. Output is the next accumulator (add-shift or compare-subtract-shift). The FSM, counter and sign handling stay in muldiv_ctrl.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; busy drops exactly in cycle 34 after the start edge.
- mult −3 × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; div −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu 100 / 0 → hi = 0x00000064, lo = 0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- mflo asserted from the cycle after start → stall high in every busy cycle and low the cycle busy drops. lo equals the new result in that cycle. A second start during busy does not alter the operation.
- mthi 0x12345678 in IDLE → hi = 0x12345678 after one edge, no stall. mtlo during busy → stall, lo unchanged until re-presented.
- reset_n pulsed low at RUN count 10 → busy = 0 and hi = lo = 0 immediately. A following multu 6 × 7 gives lo = 42, hi = 0 with full latency.
